stepper_param: RTL and testbench
================================

// Module: stepper_param
// PURPOSE
//  Parametrised successor to the fixed 6-step clock stepper.
//  - Generates a one-hot step sequence of NUM_STEPS phases that sequences control-unit enables/sets.
//  - Adds run control, hold (stall), early end of instruction, halt and an instruction-cycle counter.
//  - Sits between the system clock and the control-unit decode logic.
// PARAMETERS
//  NUM_STEPS  6  number of step phases per instruction cycle; legal range >= 2
//  CNT_W      8  width of the completed-cycle counter
//  IDX_W      $clog2(NUM_STEPS)  width of step_idx; localparam, not overridable
// PORTS
//  clk         in   1          system clock; all logic on the rising edge
//  reset       in   1          synchronous, active-high reset
//  enable      in   1          run request; sampled in IDLE and at each cycle end
//  hold        in   1          stall: freeze the current step
//  early_end   in   1          end the instruction after the current step
//  halt        in   1          request a stop at the end of the current cycle (latched)
//  step        out  NUM_STEPS  one-hot active step, bit 0 = step 1; all-zero when not running
//  step_idx    out  IDX_W      binary index of the active step; 0 when not running
//  cycle_done  out  1          one-clock pulse when a cycle completes
//  cycle_count out  CNT_W      number of completed cycles, wraps modulo 2^CNT_W
//  halted      out  1          high while in HALTED
// BEHAVIOUR
//  Reset values: state=IDLE, step=0, step_idx=0, cycle_done=0, cycle_count=0, halted=0, halt_pend=0.
//  States: IDLE, RUN, HALTED. All outputs are registered.
//  IDLE
//   - enable=1 -> next clk: RUN, step=1 (idx 0).
//  RUN, one action per clk, priority reset > hold > end-of-cycle > advance:
//   - hold=1: step, idx and counter hold; cycle_done=0.
//     early_end and enable are ignored that clk; halt is still latched.
//   - End of cycle: idx==NUM_STEPS-1, or early_end=1 at any idx.
//     - cycle_done=1 next clk; cycle_count += 1.
//     - Then, first match wins:
//       1. halt_pend or halt=1 -> HALTED, step=0, halted=1, halt_pend cleared.
//       2. enable=0 -> IDLE, step=0.
//       3. Otherwise -> step=1 (idx 0). Back-to-back cycles have no gap clock.
//   - Otherwise: step shifts left one bit and idx increments.
//  Halt latching
//   - A halt pulse in RUN sets halt_pend.
//   - halt in IDLE -> HALTED next clk.
//  HALTED
//   - Terminal. Exit only by reset; enable has no effect.
//  Boundaries
//   - early_end at the last step counts as one cycle end, never two.
//   - early_end at idx 0 gives a 1-step cycle.
//   - cycle_count wraps from 2^CNT_W-1 to 0 with no flag.
//   - cycle_done is low on every clk that is not immediately after a cycle end.
//   - Reset asserted mid-cycle -> all reset values next clk, regardless of hold.
//  Invariant: step is one-hot in RUN, zero otherwise; step == (1<<step_idx) in RUN.
// CONFIGURATION
//  STEPPER_SINGLE_STEP_EN defined
//   - Adds input ports ss_mode (1 bit) and ss_go (1 bit).
//   - In RUN with ss_mode=1, an unheld clk acts (advance or cycle end) only when ss_go=1.
//     Otherwise the clk behaves like hold=1.
//   - ss_go is level-sampled with no edge detect; it is ignored outside RUN.
//  STEPPER_SINGLE_STEP_EN undefined
//   - ss_mode and ss_go do not exist; the block advances on every unheld clk.
// TESTING (NUM_STEPS=6, CNT_W=8 unless noted)
//  1. reset, enable=1 for 14 clks
//     -> step 000001..100000, then 000001 again with no gap.
//     -> cycle_done pulses on the clk step returns to 000001; cycle_count=2 after 13 clks.
//  2. hold=1 for 3 clks while step=000100
//     -> step stays 000100 and idx stays 2; then advances to 001000 on the first clk after release.
//  3. early_end=1 at idx 2
//     -> next clk step=000001 and cycle_done=1; cycle_count +1.
//     -> early_end at idx 5 also gives +1, not +2.
//  4. halt pulse at idx 1
//     -> steps continue to idx 5; next clk step=0, halted=1, cycle_done=1.
//     -> enable=1 afterwards: no change; reset clears halted.
//  5. reset at idx 3 while hold=1 -> next clk all outputs at reset values.
//  6. NUM_STEPS=2, CNT_W=2, 9 cycles -> step alternates 01/10; cycle_count wraps 3->0.
//     With STEPPER_SINGLE_STEP_EN defined, ss_mode=1: one advance per ss_go pulse only.

Source files
------------

// File: rtl/stepper_param.sv
// stepper_param: parametrised one-hot instruction-cycle stepper.
// Sequences NUM_STEPS phases. Adds run control, hold, early end of
// instruction, latched halt and a completed-cycle counter.
// Optional feature: define STEPPER_SINGLE_STEP_EN to add the ss_mode/ss_go
// single-step gating inputs.
module stepper_param #(
    parameter int NUM_STEPS = 6,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         hold,
    input  logic                         early_end,
    input  logic                         halt,
`ifdef STEPPER_SINGLE_STEP_EN
    input  logic                         ss_mode,
    input  logic                         ss_go,
`endif
    output logic [NUM_STEPS-1:0]         step,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         cycle_done,
    output logic [CNT_W-1:0]             cycle_count,
    output logic                         halted
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam logic [NUM_STEPS-1:0] FIRST_STEP = NUM_STEPS'(1);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    logic   halt_pend;
    logic   stall;
    logic   cycle_end;

    // Freeze condition for a RUN clock: explicit hold, or single-step mode
    // waiting for a go level.
`ifdef STEPPER_SINGLE_STEP_EN
    always_comb begin
        stall = hold | (ss_mode & ~ss_go);
    end
`else
    always_comb begin
        stall = hold;
    end
`endif

    // A cycle ends on the last step or on early_end at any step; both
    // together still count as a single cycle end.
    always_comb begin
        cycle_end = (step_idx == LAST_IDX) | early_end;
    end

    // Main sequencer: state, step vector, counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            step_idx    <= '0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            halted      <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (enable) begin
                        state    <= RUN;
                        step     <= FIRST_STEP;
                        step_idx <= '0;
                    end
                end
                RUN: begin
                    // halt is latched on every RUN clock, held or not; the
                    // clear on entry to HALTED below overrides this.
                    if (halt) begin
                        halt_pend <= 1'b1;
                    end
                    if (!stall) begin
                        if (cycle_end) begin
                            cycle_done  <= 1'b1;
                            cycle_count <= cycle_count + 1'b1;
                            if (halt_pend || halt) begin
                                state     <= HALTED;
                                step      <= '0;
                                step_idx  <= '0;
                                halted    <= 1'b1;
                                halt_pend <= 1'b0;
                            end else if (!enable) begin
                                state    <= IDLE;
                                step     <= '0;
                                step_idx <= '0;
                            end else begin
                                step     <= FIRST_STEP;
                                step_idx <= '0;
                            end
                        end else begin
                            step     <= {step[NUM_STEPS-2:0], 1'b0};
                            step_idx <= step_idx + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state    <= IDLE;
                    step     <= '0;
                    step_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_param.sv
// tb_stepper_param: directed self-checking bench for stepper_param.
// u1 uses the default 6-step / 8-bit counter build; u2 uses 2 steps and a
// 2-bit counter to exercise counter wrap.
module tb_stepper_param;

    logic clk = 1'b0;
    logic reset, enable, hold, early_end, halt;
    logic reset2, enable2;
    logic ss_mode, ss_go;

    logic [5:0] step;
    logic [2:0] step_idx;
    logic       cycle_done;
    logic [7:0] cycle_count;
    logic       halted;

    logic [1:0] step2;
    logic [0:0] step_idx2;
    logic       cycle_done2;
    logic [1:0] cycle_count2;
    logic       halted2;

    int nchecks = 0;
    int nfail   = 0;

    logic [18:0] obs;
    logic [18:0] exp_v;
    logic [6:0]  obs2;
    logic [6:0]  exp2;

    assign obs  = {step, step_idx, cycle_done, cycle_count, halted};
    assign obs2 = {step2, step_idx2, cycle_done2, cycle_count2, halted2};

    stepper_param #(.NUM_STEPS(6), .CNT_W(8)) u1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hold       (hold),
        .early_end  (early_end),
        .halt       (halt),
`ifdef STEPPER_SINGLE_STEP_EN
        .ss_mode    (ss_mode),
        .ss_go      (ss_go),
`endif
        .step       (step),
        .step_idx   (step_idx),
        .cycle_done (cycle_done),
        .cycle_count(cycle_count),
        .halted     (halted)
    );

    stepper_param #(.NUM_STEPS(2), .CNT_W(2)) u2 (
        .clk        (clk),
        .reset      (reset2),
        .enable     (enable2),
        .hold       (1'b0),
        .early_end  (1'b0),
        .halt       (1'b0),
`ifdef STEPPER_SINGLE_STEP_EN
        .ss_mode    (1'b0),
        .ss_go      (1'b0),
`endif
        .step       (step2),
        .step_idx   (step_idx2),
        .cycle_done (cycle_done2),
        .cycle_count(cycle_count2),
        .halted     (halted2)
    );

    always #5 clk = ~clk;

    // Expected {step, idx, done, count, halted} for the 6-step instance.
    function automatic logic [18:0] ex(input int idx, input bit run,
                                       input bit d, input int c, input bit h);
        logic [5:0] s;
        logic [2:0] i;
        s = run ? 6'(1 << idx) : 6'd0;
        i = run ? 3'(idx) : 3'd0;
        return {s, i, d, 8'(c), h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        reset = 1'b1; enable = 1'b0; hold = 1'b0; early_end = 1'b0; halt = 1'b0;
        tick();
        reset = 1'b0; enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; hold = 1'b0; early_end = 1'b0; halt = 1'b0;
        tick();
        reset = 1'b0;
        exp_v = ex(0, 1'b0, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL reset_values: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_sequence();
        enable = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_v = ex((k - 1) % 6, 1'b1, (k > 1) && ((k - 1) % 6 == 0), (k - 1) / 6, 1'b0);
            nchecks++;
            if (obs !== exp_v) begin
                nfail++;
                $display("FAIL sequence clk %0d: got %h expected %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        tick();
        exp_v = ex(2, 1'b1, 1'b0, 2, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL hold_pre: got %h expected %h", obs, exp_v);
        end
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            nchecks++;
            if (obs !== exp_v) begin
                nfail++;
                $display("FAIL hold clk %0d: got %h expected %h", k, obs, exp_v);
            end
        end
        hold = 1'b0;
        tick();
        exp_v = ex(3, 1'b1, 1'b0, 2, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL hold_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_early_end();
        start_run();
        early_end = 1'b1;
        tick();
        exp_v = ex(0, 1'b1, 1'b1, 1, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL early_end_idx0: got %h expected %h", obs, exp_v);
        end
        early_end = 1'b0;
        tick();
        tick();
        early_end = 1'b1;
        tick();
        exp_v = ex(0, 1'b1, 1'b1, 2, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL early_end_idx2: got %h expected %h", obs, exp_v);
        end
        early_end = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_v = ex(k, 1'b1, 1'b0, 2, 1'b0);
            nchecks++;
            if (obs !== exp_v) begin
                nfail++;
                $display("FAIL early_end_adv %0d: got %h expected %h", k, obs, exp_v);
            end
        end
        early_end = 1'b1;
        tick();
        exp_v = ex(0, 1'b1, 1'b1, 3, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL early_end_idx5: got %h expected %h", obs, exp_v);
        end
        early_end = 1'b0;
        tick();
        exp_v = ex(1, 1'b1, 1'b0, 3, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL early_end_single_count: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_enable_drop();
        start_run();
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        exp_v = ex(5, 1'b1, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL enable_drop_last: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = ex(0, 1'b0, 1'b1, 1, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL enable_drop_idle: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = ex(0, 1'b0, 1'b0, 1, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL enable_drop_stay: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_halt();
        start_run();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int k = 3; k <= 5; k++) tick();
        exp_v = ex(5, 1'b1, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL halt_pending_run: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = ex(0, 1'b0, 1'b1, 1, 1'b1);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL halt_enter: got %h expected %h", obs, exp_v);
        end
        enable = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        exp_v = ex(0, 1'b0, 1'b0, 1, 1'b1);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL halt_terminal: got %h expected %h", obs, exp_v);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0;
        exp_v = ex(0, 1'b0, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL halt_reset: got %h expected %h", obs, exp_v);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        exp_v = ex(0, 1'b0, 1'b0, 0, 1'b1);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL halt_from_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_hold();
        start_run();
        for (int k = 0; k < 3; k++) tick();
        hold = 1'b1; reset = 1'b1;
        tick();
        exp_v = ex(0, 1'b0, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL reset_mid_hold: got %h expected %h", obs, exp_v);
        end
        hold = 1'b0; reset = 1'b0; enable = 1'b0;
    endtask

    task automatic test_wrap();
        reset2 = 1'b1; enable2 = 1'b0;
        tick();
        reset2 = 1'b0; enable2 = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            exp2 = {2'(1 << ((k - 1) % 2)), 1'((k - 1) % 2),
                    1'((k > 1) && ((k - 1) % 2 == 0)), 2'(((k - 1) / 2) % 4), 1'b0};
            nchecks++;
            if (obs2 !== exp2) begin
                nfail++;
                $display("FAIL wrap clk %0d: got %h expected %h", k, obs2, exp2);
            end
        end
        enable2 = 1'b0;
    endtask

`ifdef STEPPER_SINGLE_STEP_EN
    task automatic test_single_step();
        ss_mode = 1'b1; ss_go = 1'b0;
        start_run();
        tick();
        tick();
        exp_v = ex(0, 1'b1, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL ss_wait: got %h expected %h", obs, exp_v);
        end
        ss_go = 1'b1;
        tick();
        ss_go = 1'b0;
        tick();
        exp_v = ex(1, 1'b1, 1'b0, 0, 1'b0);
        nchecks++;
        if (obs !== exp_v) begin
            nfail++;
            $display("FAIL ss_one_advance: got %h expected %h", obs, exp_v);
        end
        ss_mode = 1'b0;
        enable = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; hold = 1'b0; early_end = 1'b0; halt = 1'b0;
        reset2 = 1'b1; enable2 = 1'b0; ss_mode = 1'b0; ss_go = 1'b0;
        test_reset();
        test_sequence();
        test_hold();
        test_early_end();
        test_enable_drop();
        test_halt();
        test_reset_mid_hold();
        test_wrap();
`ifdef STEPPER_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
